pit_bus_sequencer: RTL and testbench



---
 rtl/pit_bus_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_pit_bus_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pit_bus_sequencer.sv
// Host-side command sequencer for the 8254 CPU bus: expands one program or
// latch-and-read command into control-word and count byte transfers.
module pit_bus_sequencer #(
  parameter int unsigned T_SETUP = 1,
  parameter int unsigned T_PULSE = 2,
  parameter int unsigned T_RECOV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [1:0]  cmd_counter,
  input  logic [1:0]  cmd_rw,
  input  logic [2:0]  cmd_mode,
  input  logic        cmd_bcd,
  input  logic [15:0] cmd_count,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        err,
  output logic        busy,
  output logic        CS,
  output logic        WR,
  output logic        RD,
  output logic        A0,
  output logic        A1,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRecov} state_e;

  localparam logic [7:0] SetupLd = 8'(T_SETUP - 1);
  localparam logic [7:0] PulseLd = 8'(T_PULSE - 1);
  localparam logic [7:0] RecovLd = 8'(T_RECOV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  // Byte being transferred: 0 control word, 1 LSB, 2 MSB.
  logic [1:0]  step_q, step_d;
  logic        op_q;
  logic [1:0]  ctr_q;
  logic [1:0]  rw_q;
  logic [15:0] count_q;
  logic [1:0]  addr_q;
  logic [7:0]  dout_q;
  logic        wr_q;
  logic [15:0] rd_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_data_q;
  logic        err_q;

  logic        accept;
  logic        illegal;
  logic        last;
  logic        has_next;
  logic [1:0]  nxt_step;
  logic [7:0]  cw;

  assign accept  = cmd_valid & cmd_ready;
  assign illegal = (cmd_counter == 2'd3);
  assign last    = (cnt_q == 8'd0);
  assign cw      = cmd_op ? {cmd_counter, 6'b000000}
                          : {cmd_counter, cmd_rw, cmd_mode, cmd_bcd};

  always_comb begin
    has_next = 1'b0;
    nxt_step = step_q;
    case (step_q)
      2'd0: begin
        if (rw_q[0]) begin
          has_next = 1'b1;
          nxt_step = 2'd1;
        end else if (rw_q[1]) begin
          has_next = 1'b1;
          nxt_step = 2'd2;
        end
      end
      2'd1: begin
        if (rw_q[1]) begin
          has_next = 1'b1;
          nxt_step = 2'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    cmd_ready = 1'b0;
    CS        = 1'b1;
    WR        = 1'b1;
    RD        = 1'b1;
    data_oe   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        // Illegal counter select is absorbed here; err is raised by the datapath.
        if (accept && !illegal) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          step_d  = 2'd0;
        end
      end
      StSetup: begin
        CS      = 1'b0;
        data_oe = wr_q;
        if (last) begin
          state_d = StStrobe;
          cnt_d   = PulseLd;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StStrobe: begin
        CS      = 1'b0;
        WR      = ~wr_q;
        RD      = wr_q;
        data_oe = wr_q;
        if (last) begin
          state_d = StHold;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        CS      = 1'b0;
        data_oe = wr_q;
        state_d = StRecov;
        cnt_d   = RecovLd;
      end
      StRecov: begin
        if (last) begin
          if (has_next) begin
            state_d = StSetup;
            cnt_d   = SetupLd;
            step_d  = nxt_step;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy = ~cmd_ready;
  end

  // Address and data only move on entry to SETUP, so they are stable for the CS-low window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= 1'b0;
      ctr_q       <= 2'd0;
      rw_q        <= 2'd0;
      count_q     <= 16'd0;
      addr_q      <= 2'd0;
      dout_q      <= 8'd0;
      wr_q        <= 1'b0;
      rd_q        <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= accept & illegal;
      rsp_valid_q <= 1'b0;
      if (accept) begin
        op_q    <= cmd_op;
        ctr_q   <= cmd_counter;
        rw_q    <= (cmd_op && cmd_rw == 2'b00) ? 2'b11 : cmd_rw;
        count_q <= cmd_count;
        rd_q    <= 16'd0;
        if (!illegal) begin
          addr_q <= 2'b11;
          dout_q <= cw;
          wr_q   <= 1'b1;
        end
      end
      if (state_q == StStrobe && last && !wr_q) begin
        if (step_q == 2'd1) rd_q[7:0] <= data_in;
        else                rd_q[15:8] <= data_in;
      end
      if (state_q == StRecov && last) begin
        if (has_next) begin
          addr_q <= ctr_q;
          wr_q   <= ~op_q;
          dout_q <= op_q ? 8'h00 : ((nxt_step == 2'd1) ? count_q[7:0] : count_q[15:8]);
        end else if (op_q) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= rd_q;
        end
      end
    end
  end

  assign A1        = addr_q[1];
  assign A0        = addr_q[0];
  assign data_out  = dout_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pit_bus_sequencer.sv
// Scoreboard bench for pit_bus_sequencer: a bus monitor pops expected byte
// transfers and read responses pushed by each scenario task.
module tb_pit_bus_sequencer;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       wr;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_counter = 2'd0;
  logic [1:0]  cmd_rw = 2'd0;
  logic [2:0]  cmd_mode = 3'd0;
  logic        cmd_bcd = 1'b0;
  logic [15:0] cmd_count = 16'd0;
  logic [7:0]  data_in;

  logic        v1, rdy1, rv1, err1, busy1, cs1, wr1, rd1, a01, a11, oe1;
  logic [15:0] rdat1;
  logic [7:0]  dout1;
  logic        v2, rdy2, rv2, err2, busy2, cs2, wr2, rd2, a02, a12, oe2;
  logic [15:0] rdat2;
  logic [7:0]  dout2;

  logic        m_ready, m_rv, m_cs, m_wr, m_rd, m_a0, m_a1, m_oe;
  logic [15:0] m_rdat;
  logic [7:0]  m_dout;

  int n_cmp = 0;
  int n_bad = 0;

  bus_t       exp_bus[$];
  logic [15:0] exp_rsp[$];
  logic [7:0] rd_vals[4];
  int         rd_idx = 0;

  always #5 clk = ~clk;

  assign v1 = cmd_valid & ~sel;
  assign v2 = cmd_valid & sel;
  assign m_ready = sel ? rdy2 : rdy1;
  assign m_rv    = sel ? rv2 : rv1;
  assign m_rdat  = sel ? rdat2 : rdat1;
  assign m_cs    = sel ? cs2 : cs1;
  assign m_wr    = sel ? wr2 : wr1;
  assign m_rd    = sel ? rd2 : rd1;
  assign m_a0    = sel ? a02 : a01;
  assign m_a1    = sel ? a12 : a11;
  assign m_oe    = sel ? oe2 : oe1;
  assign m_dout  = sel ? dout2 : dout1;
  assign data_in = (rd_idx < 4) ? rd_vals[rd_idx] : 8'h00;

  pit_bus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(cmd_op),
    .cmd_counter(cmd_counter), .cmd_rw(cmd_rw), .cmd_mode(cmd_mode), .cmd_bcd(cmd_bcd),
    .cmd_count(cmd_count), .rsp_valid(rv1), .rsp_data(rdat1), .err(err1), .busy(busy1),
    .CS(cs1), .WR(wr1), .RD(rd1), .A0(a01), .A1(a11), .data_out(dout1), .data_oe(oe1),
    .data_in(data_in)
  );

  pit_bus_sequencer #(.T_SETUP(2), .T_PULSE(3), .T_RECOV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_ready(rdy2), .cmd_op(cmd_op),
    .cmd_counter(cmd_counter), .cmd_rw(cmd_rw), .cmd_mode(cmd_mode), .cmd_bcd(cmd_bcd),
    .cmd_count(cmd_count), .rsp_valid(rv2), .rsp_data(rdat2), .err(err2), .busy(busy2),
    .CS(cs2), .WR(wr2), .RD(rd2), .A0(a02), .A1(a12), .data_out(dout2), .data_oe(oe2),
    .data_in(data_in)
  );

  // Bus monitor: measures each CS-low window and scores it against exp_bus.
  logic       in_cs = 1'b0;
  logic       moved = 1'b0;
  logic       prev_rd = 1'b1;
  logic [1:0] c_addr = 2'd0;
  logic [7:0] c_data = 8'd0;
  int         cs_n = 0, wr_n = 0, rd_n = 0, oe_n = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_cs = 1'b0;
      prev_rd = 1'b1;
    end else begin
      int exp_cs;
      int exp_pl;
      bus_t e;
      exp_cs = sel ? 6 : 4;
      exp_pl = sel ? 3 : 2;
      n_cmp++;
      if (!(m_wr || m_rd) || (m_cs && !(m_wr && m_rd))) begin
        n_bad++;
        $display("FAIL strobes CS=%b WR=%b RD=%b, want no strobe with CS high and not both low",
                 m_cs, m_wr, m_rd);
      end
      if (m_rd && !prev_rd) rd_idx++;
      prev_rd = m_rd;
      if (!m_cs) begin
        if (!in_cs) begin
          in_cs = 1'b1; c_addr = {m_a1, m_a0}; c_data = m_dout;
          cs_n = 0; wr_n = 0; rd_n = 0; oe_n = 0; moved = 1'b0;
        end
        cs_n++;
        if (!m_wr) wr_n++;
        if (!m_rd) rd_n++;
        if (m_oe) oe_n++;
        if ({m_a1, m_a0} !== c_addr || m_dout !== c_data) moved = 1'b1;
      end else if (in_cs) begin
        in_cs = 1'b0;
        n_cmp++;
        if (exp_bus.size() == 0) begin
          n_bad++;
          $display("FAIL bus_unexpected got addr=%b data=%h, want no bus cycle", c_addr, c_data);
        end else begin
          e = exp_bus.pop_front();
          if (c_addr !== e.addr || (e.wr && c_data !== e.data)) begin
            n_bad++;
            $display("FAIL bus_byte got addr=%b data=%h, want addr=%b data=%h",
                     c_addr, c_data, e.addr, e.data);
          end
          n_cmp++;
          if (e.wr ? (wr_n != exp_pl || rd_n != 0 || oe_n != cs_n)
                   : (rd_n != exp_pl || wr_n != 0 || oe_n != 0)) begin
            n_bad++;
            $display("FAIL bus_strobe got wr_low=%0d rd_low=%0d oe=%0d, want %s low %0d oe=%0d",
                     wr_n, rd_n, oe_n, e.wr ? "WR" : "RD", exp_pl, e.wr ? cs_n : 0);
          end
          n_cmp++;
          if (cs_n != exp_cs || moved) begin
            n_bad++;
            $display("FAIL bus_window got cs_low=%0d moved=%b, want cs_low=%0d moved=0",
                     cs_n, moved, exp_cs);
          end
        end
      end
      if (m_rv) begin
        n_cmp++;
        if (exp_rsp.size() == 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected got %h, want no response", m_rdat);
        end else if (m_rdat !== exp_rsp[0]) begin
          n_bad++;
          $display("FAIL rsp_data got %h, want %h", m_rdat, exp_rsp[0]);
          void'(exp_rsp.pop_front());
        end else begin
          void'(exp_rsp.pop_front());
        end
      end
    end
  end

  task automatic send_cmd(input logic op, input logic [1:0] ctr, input logic [1:0] rw,
                          input logic [2:0] mode, input logic bcd, input logic [15:0] cnt,
                          output int waited);
    cmd_op = op; cmd_counter = ctr; cmd_rw = rw; cmd_mode = mode; cmd_bcd = bcd;
    cmd_count = cnt; cmd_valid = 1'b1;
    waited = 0;
    while (!m_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!m_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic push_bus(input logic [1:0] a, input logic [7:0] d, input logic w);
    bus_t e;
    e.addr = a; e.data = d; e.wr = w;
    exp_bus.push_back(e);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({rdy1, busy1, cs1, wr1, rd1, a11, a01, oe1, rv1, err1} !== 10'b1011100000) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b, want 1011100000",
               {rdy1, busy1, cs1, wr1, rd1, a11, a01, oe1, rv1, err1});
    end
    n_cmp++;
    if (dout1 !== 8'h00 || rdat1 !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_data got data_out=%h rsp_data=%h, want 00 0000", dout1, rdat1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_program;
    int w, n;
    push_bus(2'b11, 8'h32, 1'b1);
    push_bus(2'b00, 8'h05, 1'b1);
    push_bus(2'b00, 8'h00, 1'b1);
    send_cmd(1'b0, 2'd0, 2'b11, 3'd1, 1'b0, 16'h0005, w);
    wait_ready(n);
    n_cmp++;
    if (w != 0 || n != 15) begin
      n_bad++;
      $display("FAIL program_latency got wait=%0d busy=%0d, want 0 15", w, n);
    end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (exp_bus.size() != 0) begin
      n_bad++;
      $display("FAIL program_drain got %0d pending, want 0", exp_bus.size());
    end
  endtask

  task automatic test_back_to_back;
    int w1, w2, n;
    push_bus(2'b11, 8'h94, 1'b1);
    push_bus(2'b10, 8'h04, 1'b1);
    push_bus(2'b11, 8'h52, 1'b1);
    push_bus(2'b01, 8'h0a, 1'b1);
    send_cmd(1'b0, 2'd2, 2'b01, 3'd2, 1'b0, 16'h0004, w1);
    send_cmd(1'b0, 2'd1, 2'b01, 3'd1, 1'b0, 16'h000a, w2);
    wait_ready(n);
    n_cmp++;
    if (w2 != 10 || n != 10) begin
      n_bad++;
      $display("FAIL b2b_gap got wait=%0d busy=%0d, want 10 10", w2, n);
    end
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (exp_bus.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain got %0d pending, want 0", exp_bus.size());
    end
  endtask

  task automatic test_read;
    int w, n;
    rd_vals[0] = 8'h34; rd_vals[1] = 8'h12; rd_vals[2] = 8'hee; rd_vals[3] = 8'hee;
    rd_idx = 0;
    push_bus(2'b11, 8'h40, 1'b1);
    push_bus(2'b01, 8'h00, 1'b0);
    push_bus(2'b01, 8'h00, 1'b0);
    exp_rsp.push_back(16'h1234);
    send_cmd(1'b1, 2'd1, 2'b11, 3'd0, 1'b0, 16'h0000, w);
    wait_ready(n);
    n_cmp++;
    if (n != 15 || rv1 !== 1'b1 || rdat1 !== 16'h1234) begin
      n_bad++;
      $display("FAIL read_rsp got busy=%0d rsp_valid=%b rsp_data=%h, want 15 1 1234",
               n, rv1, rdat1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rv1 !== 1'b0) begin
      n_bad++;
      $display("FAIL read_pulse got rsp_valid=%b, want 0", rv1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (exp_bus.size() != 0 || exp_rsp.size() != 0) begin
      n_bad++;
      $display("FAIL read_drain got %0d/%0d pending, want 0/0", exp_bus.size(), exp_rsp.size());
    end
  endtask

  task automatic test_illegal;
    int w, n;
    send_cmd(1'b0, 2'd3, 2'b11, 3'd0, 1'b0, 16'h1111, w);
    n_cmp++;
    if (err1 !== 1'b1 || rdy1 !== 1'b1 || cs1 !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_err got err=%b ready=%b CS=%b, want 1 1 1", err1, rdy1, cs1);
    end
    push_bus(2'b11, 8'h50, 1'b1);
    push_bus(2'b01, 8'h07, 1'b1);
    send_cmd(1'b0, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0007, w);
    n_cmp++;
    if (w != 0 || err1 !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_next got wait=%0d err=%b, want 0 0", w, err1);
    end
    wait_ready(n);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (n != 10 || exp_bus.size() != 0 || rdat1 !== 16'h1234) begin
      n_bad++;
      $display("FAIL illegal_after got busy=%0d pending=%0d rsp_data=%h, want 10 0 1234",
               n, exp_bus.size(), rdat1);
    end
  endtask

  task automatic test_reset_mid;
    int w, n;
    push_bus(2'b11, 8'h32, 1'b1);
    send_cmd(1'b0, 2'd0, 2'b11, 3'd1, 1'b0, 16'h1234, w);
    repeat (6) @(posedge clk);
    #2;
    n_cmp++;
    if (wr1 !== 1'b0 || cs1 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_pre got WR=%b CS=%b, want 0 0", wr1, cs1);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cs1, wr1, rd1, oe1, rdy1, busy1, rv1, err1} !== 8'b11101000) begin
      n_bad++;
      $display("FAIL midrst_async got %b, want 11101000",
               {cs1, wr1, rd1, oe1, rdy1, busy1, rv1, err1});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_cmp++;
    if (exp_bus.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_drain got %0d pending, want 0", exp_bus.size());
    end
    push_bus(2'b11, 8'h50, 1'b1);
    push_bus(2'b01, 8'h07, 1'b1);
    send_cmd(1'b0, 2'd1, 2'b01, 3'd0, 1'b0, 16'h0007, w);
    wait_ready(n);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (w != 0 || n != 10 || exp_bus.size() != 0) begin
      n_bad++;
      $display("FAIL midrst_fresh got wait=%0d busy=%0d pending=%0d, want 0 10 0",
               w, n, exp_bus.size());
    end
  endtask

  task automatic test_params;
    int w, n;
    sel = 1'b1;
    push_bus(2'b11, 8'h60, 1'b1);
    push_bus(2'b01, 8'hab, 1'b1);
    send_cmd(1'b0, 2'd1, 2'b10, 3'd0, 1'b0, 16'hab00, w);
    wait_ready(n);
    repeat (2) @(posedge clk); #1;
    n_cmp++;
    if (w != 0 || n != 16 || exp_bus.size() != 0) begin
      n_bad++;
      $display("FAIL params_latency got wait=%0d busy=%0d pending=%0d, want 0 16 0",
               w, n, exp_bus.size());
    end
    sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish, want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_program();
    test_back_to_back();
    test_read();
    test_illegal();
    test_reset_mid();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
